// File: rtl/rf_wb_ctrl.sv
// rf_wb_ctrl: owns the register file write port. Merges the in-order
// pipeline result and the long-latency unit result into a single registered
// write per cycle, tracks registers awaiting long-latency results, and forces
// a one-cycle pipeline stall when the long-latency unit has been starved.
// Optional build macro: RF_WB_BYPASS_EN enables the decode bypass outputs.
//
// state | meaning
// IDLE  | no long-latency result blocked
// WAIT  | valid long-latency result blocked by pipeline writes, cnt counting
// FORCE | pipeline stalled, long-latency result takes the write slot
module rf_wb_ctrl #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pl_wr,
  input  logic [4:0]  pl_reg,
  input  logic [31:0] pl_data,
  input  logic        lu_valid,
  input  logic [4:0]  lu_reg,
  input  logic [31:0] lu_data,
  output logic        lu_ready,
  output logic        stall_req,
  input  logic        iss_valid,
  input  logic [4:0]  iss_reg,
  input  logic [4:0]  chk_reg1,
  input  logic [4:0]  chk_reg2,
  output logic        chk_busy1,
  output logic        chk_busy2,
  output logic        byp_hit1,
  output logic        byp_hit2,
  output logic [31:0] byp_data1,
  output logic [31:0] byp_data2,
  output logic        rf_wr,
  output logic [4:0]  wr_reg,
  output logic [31:0] wr_data
);

  typedef enum logic [1:0] {IDLE, WAIT, FORCE} state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic [31:0] sb;
  logic [31:0] sb_next;
  logic        sel_pl;
  logic        lu_acc;

  // Long-latency handshake and write-source selection for this cycle
  always_comb begin
    lu_ready = 1'b0;
    if (!rst) begin
      lu_ready = (state == FORCE) ? 1'b1 : ~pl_wr;
    end
    sel_pl = pl_wr & (state != FORCE) & ~rst;
    lu_acc = lu_valid & lu_ready;
  end

  // Scoreboard update: accepted result clears, issue sets, set wins on a tie
  always_comb begin
    sb_next = sb;
    if (lu_acc) sb_next[lu_reg] = 1'b0;
    if (iss_valid && iss_reg != 5'd0) sb_next[iss_reg] = 1'b1;
    sb_next[0] = 1'b0;
  end

  // Arbitration FSM with starvation counter and registered stall request
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      stall_req <= 1'b0;
    end else begin
      stall_req <= 1'b0;
      case (state)
        IDLE: begin
          if (lu_valid && pl_wr) begin
            state <= WAIT;
            cnt   <= 8'd1;
          end else begin
            cnt <= 8'd0;
          end
        end
        WAIT: begin
          if (!lu_valid || !pl_wr) begin
            state <= IDLE;
            cnt   <= 8'd0;
          end else if (cnt == 8'(STARVE_MAX)) begin
            state     <= FORCE;
            stall_req <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 8'd0;
        end
      endcase
    end
  end

  // Registered write port; register 0 updates address/data but never enables
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wr   <= 1'b0;
      wr_reg  <= 5'd0;
      wr_data <= 32'd0;
    end else if (sel_pl) begin
      rf_wr   <= (pl_reg != 5'd0);
      wr_reg  <= pl_reg;
      wr_data <= pl_data;
    end else if (lu_acc) begin
      rf_wr   <= (lu_reg != 5'd0);
      wr_reg  <= lu_reg;
      wr_data <= lu_data;
    end else begin
      rf_wr <= 1'b0;
    end
  end

  // Pending-register scoreboard
  always_ff @(posedge clk) begin
    if (rst) sb <= 32'd0;
    else     sb <= sb_next;
  end

  assign chk_busy1 = ~rst & sb[chk_reg1];
  assign chk_busy2 = ~rst & sb[chk_reg2];

`ifdef RF_WB_BYPASS_EN
  assign byp_hit1  = rf_wr & (wr_reg == chk_reg1);
  assign byp_hit2  = rf_wr & (wr_reg == chk_reg2);
  assign byp_data1 = wr_data;
  assign byp_data2 = wr_data;
`else
  assign byp_hit1  = 1'b0;
  assign byp_hit2  = 1'b0;
  assign byp_data1 = 32'd0;
  assign byp_data2 = 32'd0;
`endif

endmodule
